// File: rtl/rv32_mod_muldiv.sv
// Iterative RV32M multiply/divide unit; 34-cycle multiply/divide, 2-cycle fast paths.
// Optional macro RV32_MULDIV_SINGLE_CYCLE_MUL_EN: registered single-cycle multiplier for MUL*.
module rv32_mod_muldiv #(
  parameter int XLEN       = 32,
  parameter int ITER_CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      func,
  input  logic [XLEN-1:0] read0_data,
  input  logic [XLEN-1:0] read1_data,
  output logic            stall,
  output logic            valid,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [2:0]            r_func;
  logic [ITER_CNT_W-1:0] r_cnt;
  logic [2*XLEN-1:0]     r_acc;
  logic [2*XLEN-1:0]     r_mcand;
  logic [XLEN-1:0]       r_mplier;
  logic [XLEN-1:0]       r_quo;
  logic                  r_neg_res;
  logic [XLEN-1:0]       r_result;

  logic            w_a_neg, w_b_neg;
  logic [XLEN-1:0] w_a_abs, w_b_abs;
  logic            w_div_zero, w_div_ovf, w_fast;
  logic [XLEN-1:0] w_fast_res;
  logic            w_last;

  assign w_a_neg = (func == 3'b001 || func == 3'b010 || func == 3'b100 || func == 3'b110)
                   && read0_data[XLEN-1];
  assign w_b_neg = (func == 3'b001 || func == 3'b100 || func == 3'b110) && read1_data[XLEN-1];
  assign w_a_abs = w_a_neg ? (~read0_data + 1'b1) : read0_data;
  assign w_b_abs = w_b_neg ? (~read1_data + 1'b1) : read1_data;

  assign w_div_zero = func[2] && (read1_data == '0);
  assign w_div_ovf  = func[2] && !func[0] && (read0_data == {1'b1, {(XLEN-1){1'b0}}})
                      && (read1_data == '1);
  assign w_last     = (r_cnt == ITER_CNT_W'(XLEN-1));

`ifdef RV32_MULDIV_SINGLE_CYCLE_MUL_EN
  logic [2*XLEN-1:0] w_mul_full;
  assign w_mul_full = {{XLEN{w_a_neg}}, read0_data} * {{XLEN{w_b_neg}}, read1_data};
`endif

  always_comb begin
    w_fast     = w_div_zero || w_div_ovf;
    w_fast_res = '0;
    if (w_div_zero)
      w_fast_res = func[1] ? read0_data : '1;
    else if (w_div_ovf)
      w_fast_res = func[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
`ifdef RV32_MULDIV_SINGLE_CYCLE_MUL_EN
    if (!func[2]) begin
      w_fast     = 1'b1;
      w_fast_res = (func[1:0] == 2'b00) ? w_mul_full[XLEN-1:0] : w_mul_full[2*XLEN-1:XLEN];
    end
`endif
  end

  // One restoring-division step and one shift-add multiply step per CALC cycle.
  logic [XLEN:0]     w_sh_rem, w_diff;
  logic              w_q_bit;
  logic [XLEN-1:0]   w_rem_nxt, w_quo_nxt, w_rem_fix, w_quo_fix, w_calc_res;
  logic [2*XLEN-1:0] w_prod_nxt, w_prod_fix;

  always_comb begin
    w_sh_rem   = {r_acc[XLEN-1:0], r_quo[XLEN-1]};
    w_diff     = w_sh_rem - {1'b0, r_mcand[XLEN-1:0]};
    w_q_bit    = ~w_diff[XLEN];
    w_rem_nxt  = w_q_bit ? w_diff[XLEN-1:0] : w_sh_rem[XLEN-1:0];
    w_quo_nxt  = {r_quo[XLEN-2:0], w_q_bit};
    w_prod_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    w_prod_fix = r_neg_res ? (~w_prod_nxt + 1'b1) : w_prod_nxt;
    w_quo_fix  = r_neg_res ? (~w_quo_nxt + 1'b1) : w_quo_nxt;
    w_rem_fix  = r_neg_res ? (~w_rem_nxt + 1'b1) : w_rem_nxt;
    if (r_func[2])
      w_calc_res = r_func[1] ? w_rem_fix : w_quo_fix;
    else
      w_calc_res = (r_func[1:0] == 2'b00) ? w_prod_fix[XLEN-1:0] : w_prod_fix[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    stall       = 1'b0;
    valid       = 1'b0;
    case (r_state)
      S_IDLE: begin
        stall = start;
        if (start) w_state_nxt = w_fast ? S_DONE : S_CALC;
      end
      S_CALC: begin
        stall = 1'b1;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        valid       = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_func    <= '0;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_quo     <= '0;
      r_neg_res <= 1'b0;
      r_result  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_func    <= func;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_mplier  <= w_b_abs;
            r_quo     <= w_a_abs;
            r_mcand   <= {{XLEN{1'b0}}, func[2] ? w_b_abs : w_a_abs};
            // Remainder follows the dividend; everything else follows the operand signs.
            r_neg_res <= (func[2] && func[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
            if (w_fast) r_result <= w_fast_res;
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_func[2]) begin
            r_acc <= {{XLEN{1'b0}}, w_rem_nxt};
            r_quo <= w_quo_nxt;
          end else begin
            r_acc    <= w_prod_nxt;
            r_mcand  <= {r_mcand[2*XLEN-2:0], 1'b0};
            r_mplier <= {1'b0, r_mplier[XLEN-1:1]};
          end
          if (w_last) r_result <= w_calc_res;
        end
        default: ;
      endcase
    end
  end

  assign result = r_result;

endmodule

// File: doc/rv32_mod_muldiv.md
Name: rv32_mod_muldiv

Overview:
- Iterative RV32M multiply/divide unit for the rv32imc_ss core.
- Sits beside the combinational ALU on the same operand buses (read0_data, read1_data) and func encoding.
- Implements the clocked, stalling half of the execute interface: accepts one M-extension operation, holds the pipeline via stall, and returns a registered 32-bit result.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- ITER_CNT_W, 6, width of the iteration counter; must hold values 0..XLEN.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  input  1  request pulse; operation and operands are sampled when start=1 in IDLE.
- func  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- read0_data  input  32  rs1 operand.
- read1_data  input  32  rs2 operand.
- stall  output  1  pipeline hold; combinational.
- valid  output  1  one-cycle pulse marking result as new.
- result  output  32  registered result; held until the next accepted start.

Behaviour:
- Reset (rst_n=0 at a clock edge), from any state including mid-operation:
  - state goes to IDLE; valid=0, result=0, counter=0; the internal accumulator and quotient are cleared.
  - stall is still driven combinationally: stall = start while in IDLE.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - start=1 latches func and operands.
  - Signed ops (MULH, DIV, REM; rs1 only for MULHSU) store absolute values and record the sign of the result.
  - Next state is CALC, except for the fast paths below, which go straight to DONE.
- Fast paths, result available 1 cycle after start:
  - DIV/DIVU divide-by-zero: quotient = 0xFFFFFFFF.
  - REM/REMU divide-by-zero: remainder = rs1.
  - DIV overflow (rs1=0x80000000, rs2=0xFFFFFFFF): quotient = 0x80000000.
  - REM overflow (same operands): remainder = 0.
- CALC:
  - Exactly 32 iterations, one per cycle; counter counts 0..31.
  - Multiply: radix-2 shift-add into a 64-bit unsigned product.
  - Divide: restoring shift-subtract producing a 32-bit quotient and 32-bit remainder.
  - After iteration 31: apply the recorded sign correction (two's-complement negate), select the result, and go to DONE.
- Result selection:
  - MUL = product[31:0]; MULH/MULHSU/MULHU = product[63:32].
  - DIV/DIVU = quotient; REM/REMU = remainder.
  - The remainder takes the sign of the dividend.
- DONE: valid=1 for exactly this one cycle; always returns to IDLE next cycle.
- Timing:
  - Normal latency is 34 cycles from the start edge to valid (1 accept + 32 iterate + 1 done).
  - Back-to-back is allowed: a start in the cycle after DONE is accepted.
- stall:
  - = 1 when (IDLE and start) or CALC.
  - = 0 in DONE, so the pipeline advances in the same cycle valid is high.
- start is ignored in CALC and DONE; no queuing.
- func and operands may change freely after acceptance; internal copies are used.
- result keeps its last value in IDLE.

Optional Feature:
- Macro: RV32_MULDIV_SINGLE_CYCLE_MUL_EN.
- Defined:
  - Multiplies (func[2]=0) compute the full 64-bit product with a single registered multiplier.
  - IDLE goes directly to DONE, so multiply latency is 2 cycles (start edge, then valid).
  - Divides are unchanged.
- Undefined: all multiplies use the 32-iteration shift-add path, and no hardware multiplier is inferred.

Test Plan:
- Reset mid-CALC: start MUL 7*6, assert rst_n=0 at cycle 10 -> next cycle state IDLE, valid=0, result=0, stall=0 with start=0.
- MUL/MULH signed: rs1=0xFFFFFFFE(-2), rs2=0x00000003 -> MUL result 0xFFFFFFFA; MULH result 0xFFFFFFFF; MULHU result 0x00000002. Each with valid exactly 34 cycles after start, and stall high for 33 cycles.
- MULHSU: rs1=0xFFFFFFFF(-1), rs2=0xFFFFFFFF(unsigned) -> result 0xFFFFFFFF.
- DIV/REM signed: rs1=0xFFFFFFF9(-7), rs2=2 -> DIV 0xFFFFFFFD(-3); REM 0xFFFFFFFF(-1). DIVU 7/2 -> 3; REMU 7%2 -> 1.
- Corner cases:
  - DIVU 5/0 -> 0xFFFFFFFF; REM 5%0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
  - All four complete with valid 2 cycles after start.
- Back-to-back plus ignored start:
  - Hold start=1 throughout CALC -> second op accepted only in the IDLE cycle after DONE.
  - Exactly one valid pulse per accepted op.
  - With RV32_MULDIV_SINGLE_CYCLE_MUL_EN defined, MUL 3*5 -> result 15 with valid 2 cycles after start.
